dpram_fifo_ctrl: RTL

//  Streaming FIFO controller that sits directly upstream of the 16x8 dual-port RAM (dual_port) and owns both of its ports.

---
 rtl/dpram_pkg.sv | 12 +
 rtl/dual_port.sv | 19 +
 rtl/out_skid2.sv | 48 ++++
 rtl/dpram_fifo_ctrl.sv | 86 ++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
// Shared constants and types for the 16x8 dual-port RAM and its FIFO controller.
package dpram_pkg;
    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 1 << AW;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;
    typedef logic [DW-1:0] data_t;

    localparam cnt_t CNT_FULL = cnt_t'(DEPTH);
endpackage

// File: rtl/dual_port.sv
// 16x8 dual-port RAM: port A write-only, port B read-only with one-cycle registered read.
module dual_port
    import dpram_pkg::*;
(
    input  logic          clk,
    input  logic          we_a,
    input  logic [AW-1:0] add_a,
    input  logic [DW-1:0] data_a,
    input  logic          re_b,
    input  logic [AW-1:0] add_b,
    output logic [DW-1:0] out_b
);
    data_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_a) mem_q[add_a] <= data_a;
        if (re_b) out_b <= mem_q[add_b];
    end
endmodule

// File: rtl/out_skid2.sv
// Two-entry FIFO-ordered output buffer; slot0 is always the head.
module out_skid2
    import dpram_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          head_valid,
    output logic [DW-1:0] head_data,
    output logic [1:0]    occupancy
);
    logic [1:0] occ_q, occ_d;
    data_t      slot0_q, slot0_d, slot1_q, slot1_d;

    // Pop shifts slot1 forward first, then a push lands in the first free slot.
    always_comb begin
        occ_d   = occ_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        if (pop && occ_q != 2'd0) begin
            slot0_d = slot1_q;
            occ_d   = occ_q - 2'd1;
        end
        if (push && occ_d != 2'd2) begin
            if (occ_d == 2'd0) slot0_d = push_data;
            else               slot1_d = push_data;
            occ_d = occ_d + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            occ_q   <= 2'd0;
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            occ_q   <= occ_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    end

    assign head_valid = (occ_q != 2'd0);
    assign head_data  = slot0_q;
    assign occupancy  = occ_q;
endmodule

// File: rtl/dpram_fifo_ctrl.sv
// First-word-fall-through FIFO controller owning both ports of the external dual-port RAM.
module dpram_fifo_ctrl
    import dpram_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          ram_we_a,
    output logic [AW-1:0] ram_add_a,
    output logic [DW-1:0] ram_data_a,
    output logic          ram_re_b,
    output logic [AW-1:0] ram_add_b,
    input  logic [DW-1:0] ram_out_b,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);
    ptr_t       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    cnt_t       count_q, count_d;
    logic       inflight_q, inflight_d;
    logic       en_q;
    logic       wr_fire, rd_issue, pop;
    logic [1:0] occ;

    // en_q keeps both streams closed for the first cycle after reset.
    assign full     = (count_q == CNT_FULL);
    assign s_ready  = en_q & ~full;
    assign wr_fire  = s_valid & s_ready;
    assign pop      = m_valid & m_ready;
    assign rd_issue = en_q && (count_q != '0) &&
                      ((3'(occ) + 3'(inflight_q) - 3'(pop)) < 3'd2);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        inflight_d = rd_issue;
        if (wr_fire)  wr_ptr_d = wr_ptr_q + ptr_t'(1);
        if (rd_issue) rd_ptr_d = rd_ptr_q + ptr_t'(1);
        case ({wr_fire, rd_issue})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            en_q       <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            en_q       <= 1'b1;
        end
    end

    out_skid2 u_obuf (
        .clk        (clk),
        .rst        (rst),
        .push       (inflight_q),
        .push_data  (ram_out_b),
        .pop        (pop),
        .head_valid (m_valid),
        .head_data  (m_data),
        .occupancy  (occ)
    );

    assign ram_we_a   = wr_fire;
    assign ram_add_a  = wr_ptr_q;
    assign ram_data_a = s_data;
    assign ram_re_b   = rd_issue;
    assign ram_add_b  = rd_ptr_q;
    assign count      = count_q;
    assign empty      = (count_q == '0) & ~inflight_q & (occ == 2'd0);
endmodule
